// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage of the 5-stage MIPS pipeline. Owns the PC, drives the byte
// address to a combinationally-read 32-bit word instruction memory, and
// captures the returned word into the IF/ID register. Redirects for beq
// (taken flag supplied by the ID comparator) and j (decoded here) are resolved
// from the IF/ID contents. Stalls hold everything. When the PC leaves the
// loaded program, the unit flushes IF/ID and halts until reset.
//
// Parameters
//   MEM_WORDS     number of valid instruction words (PC >= MEM_WORDS*4 halts)
//   RESET_PC      word-aligned byte address loaded on reset
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   stall         hold PC, IF/ID and fetch count this cycle
//   branch_taken  ID comparator result for the beq currently in IF/ID
//   pc_out        byte address to instruction memory (registered PC)
//   instr_in      instruction word for pc_out, same cycle
//   if_id_instr   IF/ID instruction register
//   if_id_pc4     IF/ID PC+4 register
//   if_id_valid   IF/ID holds a real instruction (not a bubble)
//   halted        fetch has stopped because the PC left the program
//   fetch_count   valid instructions loaded into IF/ID since reset
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int unsigned MEM_WORDS = 42,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    output logic [31:0] pc_out,
    input  logic [31:0] instr_in,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam logic [5:0]  OpBeq   = 6'b000100;
    localparam logic [5:0]  OpJ     = 6'b000010;
    localparam logic [31:0] Nop     = 32'h0000_0000;
    // First byte address past the loaded program.
    localparam logic [31:0] PcLimit = 32'(MEM_WORDS) << 2;

    typedef enum logic [0:0] {
        StRun,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;

    // ID-stage decode of the instruction held in IF/ID.
    logic [5:0]  opcode;
    logic        is_beq;
    logic        is_j;
    logic        redirect;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] pc_plus4;
    logic        pc_out_of_range;

    assign opcode   = instr_q[31:26];
    assign is_beq   = valid_q && (opcode == OpBeq);
    assign is_j     = valid_q && (opcode == OpJ);
    assign redirect = (is_beq && branch_taken) || is_j;

    // Sign-extended word offset, already shifted to a byte offset.
    assign br_tgt   = pc4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign j_tgt    = {pc4_q[31:28], instr_q[25:0], 2'b00};

    assign pc_plus4        = pc_q + 32'd4;
    assign pc_out_of_range = (pc_q >= PcLimit);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;

        unique case (state_q)
            StRun: begin
                if (stall) begin
                    // Hold everything; ID re-evaluates the redirect next cycle.
                end else if (redirect) begin
                    pc_d    = is_j ? j_tgt : br_tgt;
                    instr_d = Nop;
                    pc4_d   = 32'h0;
                    valid_d = 1'b0;
                end else if (pc_out_of_range) begin
                    // instr_in is undefined here, so never capture it.
                    instr_d = Nop;
                    pc4_d   = 32'h0;
                    valid_d = 1'b0;
                    state_d = StHalt;
                end else begin
                    instr_d = instr_in;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                    count_d = count_q + 32'd1;
                end
            end
            StHalt: begin
                // Frozen until reset.
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            instr_q <= Nop;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign pc_out      = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign halted      = (state_q == StHalt);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// Testbench for instruction_fetch_unit: a small program memory, a behavioural
// reference model compared every cycle, and hand-computed literal checkpoints.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam int unsigned Words = 42;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:Words-1];

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    instruction_fetch_unit #(
        .MEM_WORDS (Words),
        .RESET_PC  (32'h0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .pc_out       (pc_out),
        .instr_in     (instr_in),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory; garbage past the program.
    assign instr_in = (pc_out < Words * 4) ? mem[pc_out[7:2]] : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_pc, m_ir, m_pc4, m_cnt;
    logic        m_v, m_halt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc   <= 32'h0;
            m_ir   <= 32'h0;
            m_pc4  <= 32'h0;
            m_v    <= 1'b0;
            m_halt <= 1'b0;
            m_cnt  <= 32'h0;
        end else if (m_halt || stall) begin
            // nothing moves
        end else if (m_v && m_ir[31:26] == 6'd4 && branch_taken) begin
            m_pc  <= m_pc4 + ({{16{m_ir[15]}}, m_ir[15:0]} * 32'd4);
            m_ir  <= 32'h0;
            m_pc4 <= 32'h0;
            m_v   <= 1'b0;
        end else if (m_v && m_ir[31:26] == 6'd2) begin
            m_pc  <= (m_pc4 & 32'hF000_0000) | ({6'b0, m_ir[25:0]} * 32'd4);
            m_ir  <= 32'h0;
            m_pc4 <= 32'h0;
            m_v   <= 1'b0;
        end else if (m_pc >= Words * 4) begin
            m_ir   <= 32'h0;
            m_v    <= 1'b0;
            m_halt <= 1'b1;
        end else begin
            m_ir  <= mem[m_pc[7:2]];
            m_pc4 <= m_pc + 32'd4;
            m_v   <= 1'b1;
            m_pc  <= m_pc + 32'd4;
            m_cnt <= m_cnt + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp pc_out", pc_out, m_pc);
            check("cmp if_id_instr", if_id_instr, m_ir);
            check("cmp if_id_valid", {31'b0, if_id_valid}, {31'b0, m_v});
            check("cmp halted", {31'b0, halted}, {31'b0, m_halt});
            check("cmp fetch_count", fetch_count, m_cnt);
            if (!m_halt) check("cmp if_id_pc4", if_id_pc4, m_pc4);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        for (int i = 0; i < Words; i++) mem[i] = 32'h014B_4820 + i;  // R-type fillers
        mem[0]  = 32'h2008_0020;  // addi
        mem[11] = 32'h1232_0012;  // beq +0x12 words -> 0x78
        mem[30] = 32'h1000_FFF8;  // beq -8 words -> 0x5C
        mem[23] = 32'h1000_0005;  // beq, left not taken
        mem[24] = 32'h0800_0028;  // j 0xA0
        mem[40] = 32'h0800_003F;  // j 0xFC (out of program)

        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        for (int c = 1; c <= 30; c++) begin
            stall = (c == 3) || (c == 14) || (c == 15) || (c >= 25 && (c % 2 == 1));
            branch_taken = (c == 3) || (c == 6) || (c >= 14 && c <= 18) || (c == 21) || (c >= 25);
            @(negedge clk);
            case (c)
                1: begin
                    check("seq instr", if_id_instr, 32'h2008_0020);
                    check("seq pc4", if_id_pc4, 32'h4);
                    check("seq pc", pc_out, 32'h4);
                    check("seq count", fetch_count, 32'd1);
                end
                3: begin
                    check("stall pc", pc_out, 32'h8);
                    check("stall count", fetch_count, 32'd2);
                end
                13: begin
                    check("beq in ifid", if_id_instr, 32'h1232_0012);
                    check("beq pc4", if_id_pc4, 32'h30);
                    check("beq count", fetch_count, 32'd12);
                end
                15: begin
                    check("stall beq pc", pc_out, 32'h30);
                    check("stall beq instr", if_id_instr, 32'h1232_0012);
                end
                16: begin
                    check("br tgt", pc_out, 32'h78);
                    check("br flush valid", {31'b0, if_id_valid}, 32'h0);
                    check("br flush instr", if_id_instr, 32'h0);
                    check("br count", fetch_count, 32'd12);
                end
                18: check("back br tgt", pc_out, 32'h5C);
                20: begin
                    check("not taken instr", if_id_instr, 32'h0800_0028);
                    check("not taken pc", pc_out, 32'h64);
                    check("not taken count", fetch_count, 32'd15);
                end
                21: begin
                    check("j tgt", pc_out, 32'hA0);
                    check("j flush valid", {31'b0, if_id_valid}, 32'h0);
                end
                23: begin
                    check("j oor pc", pc_out, 32'hFC);
                    check("j oor not halted", {31'b0, halted}, 32'h0);
                end
                24: begin
                    check("halt", {31'b0, halted}, 32'h1);
                    check("halt pc", pc_out, 32'hFC);
                    check("halt count", fetch_count, 32'd16);
                end
                30: begin
                    check("frozen pc", pc_out, 32'hFC);
                    check("frozen count", fetch_count, 32'd16);
                    check("frozen halted", {31'b0, halted}, 32'h1);
                end
                default: ;
            endcase
        end

        // Asynchronous reset out of HALT, mid-cycle.
        stall = 1'b0;
        branch_taken = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst pc", pc_out, 32'h0);
        check("rst instr", if_id_instr, 32'h0);
        check("rst valid", {31'b0, if_id_valid}, 32'h0);
        check("rst halted", {31'b0, halted}, 32'h0);
        check("rst count", fetch_count, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rerun pc", pc_out, 32'hC);
        check("rerun count", fetch_count, 32'd3);
        check("rerun instr", if_id_instr, mem[2]);

        // Asynchronous reset mid-run.
        #2 reset = 1'b1;
        #1;
        check("rst2 pc", pc_out, 32'h0);
        check("rst2 count", fetch_count, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
